// File: rtl/sbasu3_spi_gpio_top.sv
`default_nettype none
// ============================================================================
//  Module   : sbasu3_spi_gpio_top
//  Brief    : SPI-slave (mode 0, MSB first) register block driving a 7-bit
//             general-purpose output port. Two-byte transactions: a command
//             byte (write flag + 3-bit address) followed by a data byte.
//             All pins are packed onto one 8-bit input and one 8-bit output.
//  Revision : 1.0  initial release
// ============================================================================
module sbasu3_spi_gpio_top (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    // ------------------------------------------------------------------------
    // Register addresses
    // ------------------------------------------------------------------------
    localparam logic [2:0] C_ADDR_CTRL     = 3'd0;
    localparam logic [2:0] C_ADDR_GPIO_OUT = 3'd1;
    localparam logic [2:0] C_ADDR_GPIO_IN  = 3'd2;
    localparam int         C_OE_BIT        = 4;

    typedef enum logic [0:0] {
        ST_CMD  = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Unpacked pins
    // ------------------------------------------------------------------------
    logic       clk;
    logic       rst_n;
    logic       w_ss_pin;
    logic       w_sclk_pin;
    logic       w_mosi_pin;
    logic [2:0] w_gpio_in;

    assign clk        = io_in[0];
    assign rst_n      = io_in[1];
    assign w_ss_pin   = io_in[2];
    assign w_sclk_pin = io_in[3];
    assign w_mosi_pin = io_in[4];
    assign w_gpio_in  = io_in[7:5];

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic       r_ss_meta,   r_ss_sync;
    logic       r_sclk_meta, r_sclk_sync, r_sclk_dly;
    logic       r_mosi_meta, r_mosi_sync;

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic       r_cmd_wr;
    logic [2:0] r_cmd_addr;
    logic [7:0] r_ctrl;
    logic [7:0] r_gpio_out;
    logic [6:0] r_gpio_drive;

    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic [7:0] w_rx_byte;
    logic [7:0] w_rd_data;

    // Two-flop synchronizers for the SPI pins plus a delayed sclk copy for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ss_meta   <= 1'b0;
            r_ss_sync   <= 1'b0;
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_dly  <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_ss_meta   <= w_ss_pin;
            r_ss_sync   <= r_ss_meta;
            r_sclk_meta <= w_sclk_pin;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_dly  <= r_sclk_sync;
            r_mosi_meta <= w_mosi_pin;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    // Edges only count while the synchronized select is high, so an edge that
    // lands in the same cycle select drops is ignored.
    assign w_sclk_rise = r_ss_sync &  r_sclk_sync & ~r_sclk_dly;
    assign w_sclk_fall = r_ss_sync & ~r_sclk_sync &  r_sclk_dly;
    assign w_rx_byte   = {r_rx_shift[6:0], r_mosi_sync};

    // Read-data mux addressed by the incoming command byte; GPIO_IN is the live pin value
    always_comb begin
        w_rd_data = 8'h00;
        case (w_rx_byte[6:4])
            C_ADDR_CTRL:     w_rd_data = r_ctrl;
            C_ADDR_GPIO_OUT: w_rd_data = r_gpio_out;
            C_ADDR_GPIO_IN:  w_rd_data = {5'b0, w_gpio_in};
            default:         w_rd_data = 8'h00;
        endcase
    end

    // SPI bit engine, CMD/DATA sequencer, register file and registered GPIO drive
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_CMD;
            r_bit_cnt    <= 3'd0;
            r_rx_shift   <= 8'h00;
            r_tx_shift   <= 8'h00;
            r_cmd_wr     <= 1'b0;
            r_cmd_addr   <= 3'd0;
            r_ctrl       <= 8'h00;
            r_gpio_out   <= 8'h00;
            r_gpio_drive <= 7'd0;
        end else begin
            if (!r_ss_sync) begin
                // Deselected: drop any partial byte; the CMD/DATA phase is kept.
                r_bit_cnt  <= 3'd0;
                r_rx_shift <= 8'h00;
            end else if (w_sclk_rise) begin
                r_rx_shift <= w_rx_byte;
                r_bit_cnt  <= r_bit_cnt + 3'd1;   // wraps to 0 on the 8th bit
                if (r_bit_cnt == 3'd7) begin
                    case (r_state)
                        ST_CMD: begin
                            r_cmd_wr   <= w_rx_byte[7];
                            r_cmd_addr <= w_rx_byte[6:4];
                            r_tx_shift <= w_rx_byte[7] ? 8'h00 : w_rd_data;
                            r_state    <= ST_DATA;
                        end
                        default: begin
                            if (r_cmd_wr) begin
                                if (r_cmd_addr == C_ADDR_CTRL)
                                    r_ctrl <= w_rx_byte;
                                else if (r_cmd_addr == C_ADDR_GPIO_OUT)
                                    r_gpio_out <= w_rx_byte;
                            end
                            r_tx_shift <= 8'h00;
                            r_state    <= ST_CMD;
                        end
                    endcase
                end
            end else if (w_sclk_fall && (r_bit_cnt != 3'd0)) begin
                // The fall trailing a completed byte has no next bit to present;
                // skipping it keeps a freshly loaded read reply intact for the next frame.
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end

            r_gpio_drive <= r_ctrl[C_OE_BIT] ? r_gpio_out[6:0] : 7'd0;
        end
    end

    assign io_out = {r_gpio_drive, r_tx_shift[7]};

endmodule
`default_nettype wire

// File: tb/tb_sbasu3_spi_gpio_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sbasu3_spi_gpio_top
//  Brief    : Self-checking bench for sbasu3_spi_gpio_top. A table of
//             command/data transactions with expected io_out and read-back
//             bytes, plus hand-written reset, aborted-byte and mid-transaction
//             reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sbasu3_spi_gpio_top;

    logic       clk;
    logic       rst_n;
    logic       ss;
    logic       sclk;
    logic       mosi;
    logic [2:0] gpio_in;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int n_tests;
    int n_fail;

    assign io_in = {gpio_in, mosi, sclk, ss, rst_n, clk};

    sbasu3_spi_gpio_top dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    // 2 ns system clock
    initial clk = 1'b0;
    always #1 clk = ~clk;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic [2:0] gpio;
        logic [7:0] exp_rx;
        logic [7:0] exp_io;
    } vec_t;

    localparam int C_NVEC = 16;
    vec_t vecs [C_NVEC];

    function automatic vec_t mk(input logic [7:0] c, input logic [7:0] d,
                                input logic [2:0] g, input logic [7:0] rx,
                                input logic [7:0] io);
        vec_t v;
        v.cmd = c; v.data = d; v.gpio = g; v.exp_rx = rx; v.exp_io = io;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // One ss frame carrying one byte; returns the byte the master sampled on miso
    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        rx = 8'h00;
        ss = 1'b1;
        #10;
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #10;
            rx   = {rx[6:0], io_out[0]};
            sclk = 1'b1;
            #10;
            sclk = 1'b0;
        end
        #10;
        ss   = 1'b0;
        mosi = 1'b0;
        #20;
    endtask

    task automatic xact(input logic [7:0] c, input logic [7:0] d, output logic [7:0] rx);
        logic [7:0] dummy;
        spi_byte(c, dummy);
        spi_byte(d, rx);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] rx;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        ss      = 1'b0;
        sclk    = 1'b0;
        mosi    = 1'b0;
        gpio_in = 3'b000;

        //            cmd    data   gpio    rx     io_out
        vecs[0]  = mk(8'h00, 8'h00, 3'b000, 8'h00, 8'h00); // read CTRL after reset
        vecs[1]  = mk(8'h10, 8'h00, 3'b000, 8'h00, 8'h00); // read GPIO_OUT after reset
        vecs[2]  = mk(8'h90, 8'hFF, 3'b000, 8'h00, 8'h00); // GPIO_OUT=FF, OE off
        vecs[3]  = mk(8'h80, 8'h10, 3'b000, 8'h00, 8'hFE); // OE on
        vecs[4]  = mk(8'h80, 8'h00, 3'b000, 8'h00, 8'h00); // OE dropped
        vecs[5]  = mk(8'h10, 8'h00, 3'b000, 8'hFF, 8'h00); // GPIO_OUT retained
        vecs[6]  = mk(8'h80, 8'h10, 3'b000, 8'h00, 8'hFE);
        vecs[7]  = mk(8'h9B, 8'hAA, 3'b000, 8'h00, 8'h54); // low nibble of cmd ignored
        vecs[8]  = mk(8'h10, 8'h00, 3'b000, 8'hAA, 8'h54);
        vecs[9]  = mk(8'h00, 8'h00, 3'b000, 8'h10, 8'h54);
        vecs[10] = mk(8'h20, 8'h00, 3'b101, 8'h05, 8'h54); // GPIO_IN
        vecs[11] = mk(8'h30, 8'h00, 3'b000, 8'h00, 8'h54); // unmapped read
        vecs[12] = mk(8'hA0, 8'h77, 3'b010, 8'h00, 8'h54); // write GPIO_IN ignored
        vecs[13] = mk(8'h20, 8'h00, 3'b010, 8'h02, 8'h54);
        vecs[14] = mk(8'hF0, 8'h33, 3'b000, 8'h00, 8'h54); // write addr 7 ignored
        vecs[15] = mk(8'h10, 8'h00, 3'b000, 8'hAA, 8'h54);

        @(negedge clk);
        do_reset();
        chk("reset_io_out", io_out, 8'h00);

        for (int i = 0; i < C_NVEC; i++) begin
            gpio_in = vecs[i].gpio;
            xact(vecs[i].cmd, vecs[i].data, rx);
            chk($sformatf("vec%0d_rx", i), rx, vecs[i].exp_rx);
            chk($sformatf("vec%0d_io_out", i), io_out, vecs[i].exp_io);
        end
        gpio_in = 3'b000;

        // Aborted byte: three clocks with select high, then deselect
        ss = 1'b1;
        #10;
        for (int k = 0; k < 3; k++) begin
            mosi = 1'b1;
            #10 sclk = 1'b1;
            #10 sclk = 1'b0;
        end
        #10 ss = 1'b0;
        mosi = 1'b0;
        #20;
        chk("abort_io_out_unchanged", io_out, 8'h54);
        xact(8'h9B, 8'h55, rx);
        chk("abort_write_io_out", io_out, 8'hAA);
        xact(8'h10, 8'h00, rx);
        chk("abort_readback", rx, 8'h55);

        // Reset between command and data byte
        spi_byte(8'h9B, rx);
        do_reset();
        chk("midreset_io_out", io_out, 8'h00);
        xact(8'h00, 8'h00, rx);
        chk("midreset_ctrl", rx, 8'h00);
        chk("midreset_io_out2", io_out, 8'h00);
        xact(8'h10, 8'h00, rx);
        chk("midreset_gpio_out", rx, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sbasu3_spi_gpio_top.md
Name: sbasu3_spi_gpio_top

Overview:
SPI-slave-controlled register block with a 7-bit general-purpose output port, packed onto a single 8-bit input bus and a single 8-bit output bus. An external master writes or reads three byte-wide registers using two-byte transactions: a command byte followed by a data byte. All logic runs on one system clock, and the SPI pins are oversampled through synchronizers.

Parameters:
None (all widths and register addresses are fixed).

Ports:
io_in  input  8  packed inputs; [0]=sys_clk, the only clock (rising edge); [1]=rst_n, synchronous active-low reset; [2]=ss, SPI select, active-high; [3]=sclk, SPI clock, idle low; [4]=mosi; [7:5]=gpio_in.
io_out  output  8  packed outputs; [0]=miso; [7:1]=gpio_out.

Behaviour:
- Clocking and reset
  - Everything is clocked on the rising edge of io_in[0].
  - rst_n low at a clock edge clears all state on that edge: CTRL=0x00, GPIO_OUT=0x00, FSM=CMD, bit counter=0, shift register=0x00, synchronizers=0.
  - Consequently io_out=0x00 during and immediately after reset.
- Input synchronization
  - ss, sclk and mosi each pass through a 2-flop synchronizer.
  - sclk rise and fall events come from comparing the synchronized value with its one-cycle-delayed copy.
  - Required margin: each sclk half-period ≥ 4 sys_clk cycles.
- SPI framing (mode 0, MSB first, 8 bits per ss frame)
  - While synchronized ss=0: bit counter held at 0, and any partial byte is discarded.
  - The FSM phase (CMD/DATA) persists across ss-low gaps, so command and data bytes may sit in separate ss frames.
  - On each sclk rise while ss=1: shift synchronized mosi into the receive register LSB and increment the bit counter.
  - On the 8th rise: the byte is complete; act on it per the FSM below, and reset the counter to 0.
  - miso = tx_shift[7] combinationally. On each sclk fall while ss=1, tx_shift shifts left with 0 fill.
- FSM (two states)
  - CMD: the received byte is latched as the command.
    - cmd[7]: 1=write, 0=read.
    - cmd[6:4]: register address.
    - cmd[3:0]: ignored.
    - On read, tx_shift is loaded with the addressed register value in the same cycle, so its MSB is on miso before the next frame's first sclk edge.
    - On write, tx_shift is loaded with 0x00.
    - Next state: DATA.
  - DATA:
    - If write, the received byte is stored in the addressed register.
    - If read, the received byte is discarded.
    - tx_shift is loaded with 0x00. Next state: CMD.
- Register map
  - addr 0 CTRL: read/write, 8 bits. Bit 4 = OE; other bits are stored and read back but have no function.
  - addr 1 GPIO_OUT: read/write, 8 bits.
  - addr 2 GPIO_IN: read-only, value {5'b0, io_in[7:5]} sampled when the command byte completes; writes are ignored.
  - addr 3-7: reads return 0x00; writes are ignored.
- Outputs
  - io_out[7:1] = GPIO_OUT[6:0] when CTRL[4]=1, else 7'b0. Registered from the register values, so it updates 1 cycle after the data byte completes.
  - GPIO_OUT[7] is storage only.
- Boundary cases
  - Writing CTRL=0x00 drops OE, driving io_out[7:1] to 0; GPIO_OUT retains its value.
  - ss falling mid-byte: no register change and no FSM advance.
  - A sclk edge coincident with synchronized ss falling is ignored.
  - Reset mid-transaction returns to CMD, discarding any pending command.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release -> io_out=0x00; read back CTRL and GPIO_OUT both 0x00.
- Configure and drive: send 0x80/0x00, then 0x80/0x10, then 0x9B/0xAA, each byte in its own ss pulse with 10 ns sclk half-period and sys_clk period 2 ns -> io_out[7:1]=7'b0101010, io_out=0x54 while idle.
- OE gating: write GPIO_OUT=0xFF with CTRL=0x00 -> io_out[7:1]=0; then write CTRL=0x10 -> io_out[7:1]=0x7F.
- Readback: after the configure step, send 0x10 (read addr 1), then 0x00 -> master captures 0xAA on miso; 0x00 (read CTRL), then 0x00 -> captures 0x10; 0x20 with io_in[7:5]=3'b101 -> captures 0x05.
- Aborted byte: raise ss, give 3 sclk pulses, drop ss, then send 0x9B/0x55 -> GPIO_OUT=0x55 and the partial byte has no effect.
- Reset mid-transaction: send 0x9B, assert rst_n=0, release, then send 0x00/0x00 -> all registers 0x00 and io_out=0x00.
